// File: rtl/mem_arbiter.sv
// Memory arbiter: services per-CPU icache/dcache word requests over a single RAM port.
// Dcache beats icache, round-robin across CPUs, grant held across two-word dcache blocks.
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int CPUW = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 grant_valid,
  output logic [CPUW:0]        grant_id
);

  localparam logic       IDLE       = 1'b0;
  localparam logic       SERVE      = 1'b1;
  localparam logic [1:0] RAM_ACCESS = 2'b10;

  logic            state_reg, state_next;
  logic [CPUW-1:0] rr_reg, rr_next;
  logic            lock_reg, lock_next;
  logic            gnt_d_reg, gnt_d_next;
  logic [CPUW-1:0] gnt_cpu_reg, gnt_cpu_next;

  logic [31:0]     iaddr_w  [CPUS];
  logic [31:0]     daddr_w  [CPUS];
  logic [31:0]     dstore_w [CPUS];
  logic [CPUS-1:0] dreq;

  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : gen_unpack
      assign iaddr_w[gi]  = iaddr[32*gi +: 32];
      assign daddr_w[gi]  = daddr[32*gi +: 32];
      assign dstore_w[gi] = dstore[32*gi +: 32];
    end
  endgenerate

  assign dreq = dREN | dWEN;

  // Returns {found, cpu}: first requester at or after start, wrapping mod CPUS.
  function automatic logic [CPUW:0] pick_rr(input logic [CPUS-1:0] req,
                                            input logic [CPUW-1:0] start);
    logic [CPUW:0] res;
    int            idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % CPUS;
      if (req[idx]) res = {1'b1, CPUW'(idx)};
    end
    return res;
  endfunction

  logic [CPUW:0]   pick_d, pick_i;
  logic            win_found, win_d;
  logic [CPUW-1:0] win_cpu;

  assign pick_d    = pick_rr(dreq, rr_reg);
  assign pick_i    = pick_rr(iREN, rr_reg);
  assign win_found = pick_d[CPUW] | pick_i[CPUW];
  assign win_d     = pick_d[CPUW];
  assign win_cpu   = pick_d[CPUW] ? pick_d[CPUW-1:0] : pick_i[CPUW-1:0];

  logic g_req, active, done, g_blk_hi;
  logic [CPUW-1:0] rr_after;

  assign g_req    = gnt_d_reg ? dreq[gnt_cpu_reg] : iREN[gnt_cpu_reg];
  assign active   = (state_reg == SERVE) && g_req;
  assign done     = active && (ramstate == RAM_ACCESS);
  assign g_blk_hi = daddr_w[gnt_cpu_reg][2];
  assign rr_after = CPUW'((int'(gnt_cpu_reg) + 1) % CPUS);

  // RAM port follows the granted requester's live inputs; a dropped request kills the strobes.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (active) begin
      if (gnt_d_reg) begin
        ramWEN   = dWEN[gnt_cpu_reg];
        ramREN   = dREN[gnt_cpu_reg] & ~dWEN[gnt_cpu_reg];
        ramaddr  = daddr_w[gnt_cpu_reg];
        ramstore = dstore_w[gnt_cpu_reg];
      end else begin
        ramREN   = iREN[gnt_cpu_reg];
        ramaddr  = iaddr_w[gnt_cpu_reg];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    lock_next    = lock_reg;
    gnt_d_next   = gnt_d_reg;
    gnt_cpu_next = gnt_cpu_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next   = SERVE;
          gnt_d_next   = win_d;
          gnt_cpu_next = win_cpu;
        end
      end
      SERVE: begin
        if (!g_req) begin
          state_next = IDLE;
          lock_next  = 1'b0;
        end else if (done) begin
          rr_next = rr_after;
          // First word of a dcache block keeps the grant for its partner word.
          if (gnt_d_reg && !g_blk_hi && !lock_reg) begin
            lock_next = 1'b1;
          end else begin
            lock_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        lock_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      lock_reg    <= 1'b0;
      gnt_d_reg   <= 1'b0;
      gnt_cpu_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      lock_reg    <= lock_next;
      gnt_d_reg   <= gnt_d_next;
      gnt_cpu_reg <= gnt_cpu_next;
    end
  end

  generate
    for (gi = 0; gi < CPUS; gi++) begin : gen_req
      logic        hit_i, hit_d;
      logic [31:0] iload_reg, dload_reg;

      assign hit_i = done && !gnt_d_reg && (gnt_cpu_reg == CPUW'(gi));
      assign hit_d = done &&  gnt_d_reg && (gnt_cpu_reg == CPUW'(gi));

      assign iwait[gi] = ~hit_i;
      assign dwait[gi] = ~hit_d;
      assign iload[32*gi +: 32] = hit_i ? ramload : iload_reg;
      assign dload[32*gi +: 32] = (hit_d && !dWEN[gi]) ? ramload : dload_reg;

      // Hold the last delivered word so the load output stays stable between completions.
      always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
          iload_reg <= '0;
          dload_reg <= '0;
        end else begin
          if (hit_i)             iload_reg <= ramload;
          if (hit_d && !dWEN[gi]) dload_reg <= ramload;
        end
      end
    end
  endgenerate

  assign grant_valid = (state_reg == SERVE);
  assign grant_id    = {gnt_d_reg, gnt_cpu_reg};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, multi-cycle corner sequences, and randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int CPUS = 2;
  localparam int CPUW = 1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [31:0] ia [2];
  logic [31:0] da [2];
  logic [31:0] ds [2];
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        grant_valid;
  logic [1:0]  grant_id;

  assign iaddr  = {ia[1], ia[0]};
  assign daddr  = {da[1], da[0]};
  assign dstore = {ds[1], ds[0]};

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(CPUS), .CPUW(CPUW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: owner of the port, block-hold flag, fairness pointer, delivered words.
  bit          m_busy, m_isd, m_lock;
  int          m_cpu, m_rr;
  logic [1:0]  m_gid;
  logic [31:0] m_il [2];
  logic [31:0] m_dl [2];

  logic [1:0]  obs_dwait, obs_iwait;
  logic        obs_ren;
  logic [31:0] obs_store;

  task automatic m_reset();
    m_busy = 0; m_isd = 0; m_lock = 0; m_cpu = 0; m_rr = 0; m_gid = 2'b00;
    for (int n = 0; n < CPUS; n++) begin
      m_il[n] = '0;
      m_dl[n] = '0;
    end
  endtask

  function automatic bit m_greq();
    if (!m_busy) return 1'b0;
    return m_isd ? (dREN[m_cpu] | dWEN[m_cpu]) : iREN[m_cpu];
  endfunction

  task automatic model_compare();
    bit          greq, done;
    logic        er, ew;
    logic [31:0] ea, es;
    logic [1:0]  eiw, edw;
    logic [63:0] eil, edl;
    greq = m_greq();
    done = greq && (ramstate == 2'b10);
    er = greq && (m_isd ? (dREN[m_cpu] && !dWEN[m_cpu]) : 1'b1);
    ew = greq && m_isd && dWEN[m_cpu];
    ea = greq ? (m_isd ? da[m_cpu] : ia[m_cpu]) : 32'h0;
    es = (greq && m_isd) ? ds[m_cpu] : 32'h0;
    eiw = 2'b11;
    edw = 2'b11;
    eil = {m_il[1], m_il[0]};
    edl = {m_dl[1], m_dl[0]};
    if (done && !m_isd) begin
      eiw[m_cpu] = 1'b0;
      eil[32*m_cpu +: 32] = ramload;
    end
    if (done && m_isd) begin
      edw[m_cpu] = 1'b0;
      if (!dWEN[m_cpu]) edl[32*m_cpu +: 32] = ramload;
    end
    check("ramREN", 64'(ramREN), 64'(er));
    check("ramWEN", 64'(ramWEN), 64'(ew));
    check("ramaddr", 64'(ramaddr), 64'(ea));
    check("ramstore", 64'(ramstore), 64'(es));
    check("iwait", 64'(iwait), 64'(eiw));
    check("dwait", 64'(dwait), 64'(edw));
    check("iload", iload, eil);
    check("dload", dload, edl);
    check("grant_valid", 64'(grant_valid), 64'(m_busy));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    obs_dwait = dwait;
    obs_iwait = iwait;
    obs_ren   = ramREN;
    obs_store = ramstore;
  endtask

  task automatic model_step();
    bit greq, done;
    int n;
    if (!nRST) begin
      m_reset();
      return;
    end
    greq = m_greq();
    done = greq && (ramstate == 2'b10);
    if (!m_busy) begin
      for (int k = 0; k < CPUS && !m_busy; k++) begin
        n = (m_rr + k) % CPUS;
        if (dREN[n] || dWEN[n]) begin m_busy = 1; m_isd = 1; m_cpu = n; end
      end
      for (int k = 0; k < CPUS && !m_busy; k++) begin
        n = (m_rr + k) % CPUS;
        if (iREN[n]) begin m_busy = 1; m_isd = 0; m_cpu = n; end
      end
      if (m_busy) m_gid = {m_isd, m_cpu[0]};
    end else if (!greq) begin
      m_busy = 0;
      m_lock = 0;
    end else if (done) begin
      m_rr = (m_cpu + 1) % CPUS;
      if (!m_isd) m_il[m_cpu] = ramload;
      else if (!dWEN[m_cpu]) m_dl[m_cpu] = ramload;
      if (m_isd && !da[m_cpu][2] && !m_lock) m_lock = 1;
      else begin
        m_lock = 0;
        m_busy = 0;
      end
    end
  endtask

  // One clock: inputs already applied; sample at negedge, advance model, then move past posedge.
  task automatic cyc();
    @(negedge CLK);
    model_compare();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [1:0]  iren, dren, dwen, rs;
    logic [31:0] rl;
    logic        er;
    logic [31:0] ea;
    logic [1:0]  eiw, edw;
    logic [31:0] eil0, edl0, edl1;
    logic        egv;
    logic [1:0]  egid;
  } vec_t;

  vec_t        tbl [10];
  logic [1:0]  rs_seq [8];
  int          prev, cur, ncomp, w0;
  bit          seen1, t4done;
  logic [31:0] want_store;

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    for (int n = 0; n < CPUS; n++) begin ia[n] = '0; da[n] = '0; ds[n] = '0; end
    ramload = '0; ramstate = 2'b00;
    m_reset();

    // Directed table: single dcache read with block hold, then dcache-over-icache priority.
    tbl[0] = '{2'b00, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 1'b0, 32'h0,   2'b11, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00};
    tbl[1] = '{2'b00, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 1'b1, 32'h40,  2'b11, 2'b11, 32'h0, 32'h0, 32'h0, 1'b1, 2'b10};
    tbl[2] = '{2'b00, 2'b01, 2'b00, 2'b10, 32'hDEADBEEF, 1'b1, 32'h40,  2'b11, 2'b10, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 2'b10};
    tbl[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 1'b0, 32'h0,   2'b11, 2'b11, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 2'b10};
    tbl[4] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        1'b0, 32'h0,   2'b11, 2'b11, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2'b10};
    tbl[5] = '{2'b01, 2'b10, 2'b00, 2'b00, 32'h11111111, 1'b0, 32'h0,   2'b11, 2'b11, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 2'b10};
    tbl[6] = '{2'b01, 2'b10, 2'b00, 2'b10, 32'h22222222, 1'b1, 32'h204, 2'b11, 2'b01, 32'h0, 32'hDEADBEEF, 32'h22222222, 1'b1, 2'b11};
    tbl[7] = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h0,        1'b0, 32'h0,   2'b11, 2'b11, 32'h0, 32'hDEADBEEF, 32'h22222222, 1'b0, 2'b11};
    tbl[8] = '{2'b01, 2'b00, 2'b00, 2'b10, 32'h33333333, 1'b1, 32'h100, 2'b10, 2'b11, 32'h33333333, 32'hDEADBEEF, 32'h22222222, 1'b1, 2'b00};
    tbl[9] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,        1'b0, 32'h0,   2'b11, 2'b11, 32'h33333333, 32'hDEADBEEF, 32'h22222222, 1'b0, 2'b00};
    rs_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2};

    // Reset state is checked by the model comparison while nRST is low.
    cyc();
    cyc();
    nRST = 1'b1;

    ia[0] = 32'h100; ia[1] = 32'h180; da[0] = 32'h40; da[1] = 32'h204;
    for (int v = 0; v < 10; v++) begin
      iREN = tbl[v].iren; dREN = tbl[v].dren; dWEN = tbl[v].dwen;
      ramstate = tbl[v].rs; ramload = tbl[v].rl;
      @(negedge CLK);
      check($sformatf("tbl%0d_ramREN", v), 64'(ramREN), 64'(tbl[v].er));
      check($sformatf("tbl%0d_ramWEN", v), 64'(ramWEN), 64'(1'b0));
      check($sformatf("tbl%0d_ramaddr", v), 64'(ramaddr), 64'(tbl[v].ea));
      check($sformatf("tbl%0d_iwait", v), 64'(iwait), 64'(tbl[v].eiw));
      check($sformatf("tbl%0d_dwait", v), 64'(dwait), 64'(tbl[v].edw));
      check($sformatf("tbl%0d_iload0", v), 64'(iload[31:0]), 64'(tbl[v].eil0));
      check($sformatf("tbl%0d_dload0", v), 64'(dload[31:0]), 64'(tbl[v].edl0));
      check($sformatf("tbl%0d_dload1", v), 64'(dload[63:32]), 64'(tbl[v].edl1));
      check($sformatf("tbl%0d_grant_valid", v), 64'(grant_valid), 64'(tbl[v].egv));
      check($sformatf("tbl%0d_grant_id", v), 64'(grant_id), 64'(tbl[v].egid));
      model_step();
      @(posedge CLK);
      #1;
    end

    // Both dcaches stream single words: completions must alternate between CPUs.
    iREN = '0; dWEN = '0; dREN = 2'b11; da[0] = 32'h104; da[1] = 32'h20C; ramstate = 2'b10;
    prev = -1; ncomp = 0;
    for (int i = 0; i < 12; i++) begin
      ramload = $urandom;
      cyc();
      if (obs_dwait != 2'b11) begin
        cur = (obs_dwait[0] == 1'b0) ? 0 : 1;
        if (prev >= 0) check("t3_alternate", 64'(cur), 64'(1 - prev));
        prev = cur;
        ncomp++;
      end
    end
    check("t3_completions", 64'(ncomp), 64'(6));
    dREN = '0;
    cyc();
    cyc();

    // CPU0 two-word writeback must finish before CPU1's pending read gets the port.
    ramstate = 2'b10; dWEN = 2'b01; da[0] = 32'h80; ds[0] = 32'hA0A0A0A0;
    cyc();
    dREN[1] = 1'b1; da[1] = 32'h300;
    w0 = 0; seen1 = 0; t4done = 0;
    for (int i = 0; i < 12 && !t4done; i++) begin
      want_store = ds[0];
      ramload = $urandom;
      cyc();
      if (obs_ren && !seen1) begin
        seen1 = 1;
        check("t4_cpu1_after_block", 64'(w0), 64'(2));
      end
      if (obs_dwait[0] == 1'b0) begin
        check("t4_ramstore", 64'(obs_store), 64'(want_store));
        w0++;
        if (w0 == 1) begin da[0] = 32'h84; ds[0] = 32'hB1B1B1B1; end
        else dWEN[0] = 1'b0;
      end
      if (obs_dwait[1] == 1'b0) begin
        dREN[1] = 1'b0;
        t4done = 1;
      end
    end
    check("t4_finished", 64'(t4done), 64'(1));
    dREN = '0; dWEN = '0;
    cyc();
    cyc();

    // Wait held through BUSY and ERROR, single pulse on ACCESS.
    ramstate = 2'b00; dREN[0] = 1'b1; da[0] = 32'h10C;
    cyc();
    for (int i = 0; i < 8; i++) begin
      ramstate = rs_seq[i];
      ramload = $urandom;
      cyc();
      check($sformatf("t5_dwait0_c%0d", i), 64'(obs_dwait[0]), 64'(i < 7));
    end
    dREN = '0; ramstate = 2'b00;
    cyc();

    // Abort mid-serve, then asynchronous reset mid-transaction.
    dREN[0] = 1'b1; da[0] = 32'h110; ramstate = 2'b01;
    cyc();
    cyc();
    check("t6_strobe_on", 64'(obs_ren), 64'(1));
    dREN[0] = 1'b0;
    #1;
    check("t6_abort_ren", 64'(ramREN), 64'(0));
    check("t6_abort_dwait", 64'(dwait), 64'(2'b11));
    cyc();
    check("t6_idle_after_abort", 64'(grant_valid), 64'(0));
    dREN[0] = 1'b1;
    cyc();
    #1;
    check("t6_serving", 64'(ramREN), 64'(1));
    nRST = 1'b0;
    #1;
    m_reset();
    check("t6_rst_ramREN", 64'(ramREN), 64'(0));
    check("t6_rst_ramaddr", 64'(ramaddr), 64'(0));
    check("t6_rst_dwait", 64'(dwait), 64'(2'b11));
    check("t6_rst_iwait", 64'(iwait), 64'(2'b11));
    check("t6_rst_grant_valid", 64'(grant_valid), 64'(0));
    check("t6_rst_dload", dload, 64'(0));
    cyc();
    cyc();
    nRST = 1'b1;
    dREN = 2'b11; da[1] = 32'h214; ramstate = 2'b00;
    cyc();
    check("t6_rr_after_reset", 64'(grant_id), 64'(2'b10));
    dREN = '0;
    cyc();
    cyc();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < CPUS; n++) begin
        if ($urandom_range(0, 99) < 25) begin
          iREN[n] = 1'($urandom_range(0, 1));
          dREN[n] = ($urandom_range(0, 2) == 0);
          dWEN[n] = ($urandom_range(0, 3) == 0);
          ia[n] = $urandom & 32'h0000_0FFC;
          da[n] = $urandom & 32'h0000_0FFC;
          ds[n] = $urandom;
        end
      end
      ramstate = ($urandom_range(0, 9) < 5) ? 2'b10 : 2'($urandom_range(0, 3));
      ramload = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache/memory protocol: services word requests from per-CPU icache and dcache initiators and forwards them to a single RAM port with variable latency.
- Sits between the caches and RAM.
- Drives per-requester wait/load, arbitrates dcache over icache with round-robin across CPUs.
- Holds the grant across the two words of a dcache block transfer, so block fetches and writebacks are never interleaved.

Parameters:
- CPUS, 2, number of CPUs; each CPU has one icache and one dcache requester. CPUS >= 1.
- CPUW, 1, width of the round-robin pointer and grant index; max(1, clog2(CPUS)).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  CPUS  icache read request per CPU
- iaddr  in  CPUS*32  icache word address, CPU n at [32n+31:32n]
- iwait  out  CPUS  low for exactly the cycle the icache read completes
- iload  out  CPUS*32  instruction word, valid when matching iwait is low
- dREN  in  CPUS  dcache read request
- dWEN  in  CPUS  dcache write request
- daddr  in  CPUS*32  dcache word address
- dstore  in  CPUS*32  dcache write data
- dwait  out  CPUS  low for exactly the cycle the dcache access completes
- dload  out  CPUS*32  read data, valid when matching dwait is low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
- grant_valid  out  1  a transaction is in flight (debug/perf)
- grant_id  out  CPUW+1  {is_dcache, cpu index} of current grant

Behaviour:
- Reset: state IDLE, rr=0, lock=0, grant regs 0.
  - iwait and dwait all 1; iload and dload 0.
  - ramREN, ramWEN, ramaddr, ramstore all 0; grant_valid 0.
- States: IDLE, SERVE.
- IDLE:
  - If any request is pending, pick a winner, register it (grant_id), go to SERVE. RAM is not driven in IDLE.
  - Minimum latency is therefore 2 cycles, request to wait-low.
- Arbitration:
  - Any dcache request (dREN|dWEN) beats every icache request.
  - Within a class, choose the first requesting CPU searching rr, rr+1, ... mod CPUS.
  - On completion, rr <= granted cpu + 1 mod CPUS.
- Request direction: if dWEN and dREN are both high, treat it as a write.
- SERVE:
  - Drive ram signals from the granted requester's live inputs: ramaddr=addr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN or iREN.
  - When ramstate==ACCESS, combinationally pull the granted wait low. For reads, that load output = ramload in the same cycle.
  - FREE, BUSY, or ERROR: keep the wait high and keep driving (ERROR is retried implicitly).
- Completion of a dcache word with daddr[1:0]-aligned bit daddr[2]==0:
  - lock <= 1; stay in SERVE with the same grant.
  - If the requester's dREN|dWEN is low in the next cycle, go to IDLE and clear lock.
- Completion with daddr[2]==1, an icache completion, or lock already 1 with word complete: lock <= 0, go to IDLE.
- Abort: in SERVE, if the granted requester drops its request, the ram strobes drop the same cycle (combinational). Go to IDLE next cycle; no wait pulse; rr unchanged.
- Load outputs hold their last delivered value between completions; non-granted waits stay 1.
- Reset mid-transaction: immediate return to reset values; no RAM strobe after nRST falls.
- CPUS==1: rr is constant 0.

Test Plan:
1. CPU0 dREN, daddr=0x40, RAM ACCESS 1 cycle after strobe with ramload=0xDEADBEEF -> cycle t+1 ramREN=1, ramaddr=0x40; dwait[0]=0 and dload[0]=0xDEADBEEF when ACCESS; back to IDLE.
2. iREN[0] and dREN[1] asserted together -> dcache of CPU1 granted first (grant_id=2'b11); icache served only after dwait[1] pulse.
3. Both dcaches continuously request single words at addr[2]=1 -> grants alternate CPU0, CPU1, CPU0; no CPU served twice in a row.
4. CPU0 writeback 0x80/0x84 (dWEN) while CPU1 dREN pending -> both CPU0 words complete back-to-back before CPU1 gets a ram strobe; ramstore matches each dstore.
5. ramstate BUSY for 5 cycles, then ERROR for 2, then ACCESS -> dwait held 1 through all 7 cycles, single low pulse at ACCESS.
6. CPU0 drops dREN mid-SERVE, then nRST pulsed mid-transaction -> strobes drop the same cycle, no wait pulse; after reset all waits 1, ram outputs 0, rr=0.
